// File: rtl/mix_fadd.sv
// rtl/mix_fadd.sv - MIX FADD/FSUB multi-cycle adder; MIX_FADD_ROUND_EN enables round-half-up
module mix_fadd (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [30:0] in1,
    input  logic [30:0] in2,
    output logic [30:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    // Captured operands (v sign already folded with sub)
    logic        su_q, su_d, sv_q, sv_d, s1_q, s1_d;
    logic [5:0]  eu_q, eu_d, ev_q, ev_d;
    logic [23:0] fu_q, fu_d, fv_q, fv_d;

    // Aligned magnitudes: {byte1..byte6, sticky}
    logic [36:0] a_q, a_d, b_q, b_d;
    logic        sa_q, sa_d, sb_q, sb_d;

    // Working value: {carry, byte1..byte6, sticky}
    logic [37:0]       w_q, w_d;
    logic              sign_q, sign_d;
    logic signed [7:0] exp_q, exp_d;
    logic [2:0]        nshift_q, nshift_d;

    logic [30:0] result_q, result_d;
    logic        done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;

    // Alignment network signals
    logic        swap;
    logic [5:0]  el, es;
    logic [23:0] fl, fs;
    logic        sl, ss;
    logic [6:0]  ediff;
    logic [5:0]  shamt;
    logic [71:0] sh;
    logic [35:0] fs_sh;
    logic        fs_st;

`ifdef MIX_FADD_ROUND_EN
    logic [24:0] rnd;
`endif

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

    // Order operands by exponent (a zero fraction never wins) and shift the smaller one
    always_comb begin
        swap  = (fu_q == 24'd0) || ((fv_q != 24'd0) && (ev_q > eu_q));
        el    = swap ? ev_q : eu_q;
        es    = swap ? eu_q : ev_q;
        fl    = swap ? fv_q : fu_q;
        fs    = swap ? fu_q : fv_q;
        sl    = swap ? sv_q : su_q;
        ss    = swap ? su_q : sv_q;
        ediff = {1'b0, el} - {1'b0, es};
        shamt = {1'b0, ediff[2:0], 2'b00} + {2'b00, ediff[2:0], 1'b0};
        sh    = '0;
        fs_sh = '0;
        fs_st = 1'b0;
        if (fs != 24'd0) begin
            if (ediff >= 7'd6) begin
                fs_st = 1'b1;
            end else begin
                sh    = {fs, 48'd0} >> shamt;
                fs_sh = sh[71:36];
                fs_st = |sh[35:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath next values
    always_comb begin
        state_d  = state_q;
        su_d     = su_q;
        sv_d     = sv_q;
        s1_d     = s1_q;
        eu_d     = eu_q;
        ev_d     = ev_q;
        fu_d     = fu_q;
        fv_d     = fv_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        w_d      = w_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        nshift_d = nshift_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
`ifdef MIX_FADD_ROUND_EN
        rnd      = {1'b0, w_q[36:13]} + 25'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    su_d     = in1[30];
                    eu_d     = in1[29:24];
                    fu_d     = in1[23:0];
                    sv_d     = in2[30] ^ sub;
                    ev_d     = in2[29:24];
                    fv_d     = in2[23:0];
                    s1_d     = in1[30];
                    nshift_d = 3'd0;
                    busy_d   = 1'b1;
                    state_d  = S_ALIGN;
                end
            end
            S_ALIGN: begin
                a_d     = {fl, 12'd0, 1'b0};
                b_d     = {fs_sh, fs_st};
                sa_d    = sl;
                sb_d    = ss;
                exp_d   = {2'b00, el};
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sa_q == sb_q) begin
                    w_d    = {1'b0, a_q} + {1'b0, b_q};
                    sign_d = sa_q;
                end else if (a_q >= b_q) begin
                    w_d    = {1'b0, a_q - b_q};
                    sign_d = sa_q;
                end else begin
                    w_d    = {1'b0, b_q - a_q};
                    sign_d = sb_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (w_q == 38'd0) begin
                    exp_d   = 8'sd0;
                    sign_d  = s1_q;
                    state_d = S_FINISH;
                end else if (w_q[37]) begin
                    w_d     = {6'd0, w_q[37:7], |w_q[6:0]};
                    exp_d   = exp_q + 8'sd1;
`ifdef MIX_FADD_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_FINISH;
`endif
                end else if ((w_q[36:31] == 6'd0) && (nshift_q != 3'd5)) begin
                    w_d      = {1'b0, w_q[30:1], 6'd0, w_q[0]};
                    exp_d    = exp_q - 8'sd1;
                    nshift_d = nshift_q + 3'd1;
                end else begin
`ifdef MIX_FADD_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_FINISH;
`endif
                end
            end
`ifdef MIX_FADD_ROUND_EN
            S_ROUND: begin
                if (w_q[12]) begin
                    if (rnd[24]) begin
                        w_d   = {1'b0, 24'o01000000, 13'd0};
                        exp_d = exp_q + 8'sd1;
                    end else begin
                        w_d   = {1'b0, rnd[23:0], 13'd0};
                    end
                end
                state_d = S_FINISH;
            end
`endif
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (exp_q > 8'sd63) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, exp_q[5:0], w_q[36:13]};
                end else if (exp_q < 8'sd0) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, 30'd0};
                end else begin
                    ovf_d    = 1'b0;
                    if (w_q[36:13] == 24'd0) result_d = {sign_q, 30'd0};
                    else                     result_d = {sign_q, exp_q[5:0], w_q[36:13]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            su_q     <= 1'b0;
            sv_q     <= 1'b0;
            s1_q     <= 1'b0;
            eu_q     <= '0;
            ev_q     <= '0;
            fu_q     <= '0;
            fv_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            w_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            nshift_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            su_q     <= su_d;
            sv_q     <= sv_d;
            s1_q     <= s1_d;
            eu_q     <= eu_d;
            ev_q     <= ev_d;
            fu_q     <= fu_d;
            fv_q     <= fv_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            w_q      <= w_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            nshift_q <= nshift_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mix_fadd.sv
// tb/tb_mix_fadd.sv - directed self-checking bench for mix_fadd
module tb_mix_fadd;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [30:0] in1;
    logic [30:0] in2;
    logic [30:0] result;
    logic        done;
    logic        busy;
    logic        overflow;

    int checks;
    int failures;

    mix_fadd dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .in1      (in1),
        .in2      (in2),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from posedge+1 and wait (bounded) for done
    task automatic do_op(input logic [30:0] a, input logic [30:0] b, input logic s,
                         output logic [30:0] res, output logic ovf, output int lat);
        in1   = a;
        in2   = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 15) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        ovf = overflow;
    endtask

    task automatic test_reset;
        checks++;
        if (result !== 31'd0 || done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%o done=%b busy=%b ovf=%b expected all zero",
                     result, done, busy, overflow);
        end
    endtask

    // Run one vector and compare result, overflow and latency bound
    task automatic test_vector(input string name, input logic [30:0] a, input logic [30:0] b,
                               input logic s, input logic [30:0] exp_res, input logic exp_ovf);
        logic [30:0] r;
        logic        o;
        int          lat;
        do_op(a, b, s, r, o, lat);
        checks++;
        if (lat > 10) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected <= 10", name, lat);
        end
        checks++;
        if (r !== exp_res) begin
            failures++;
            $display("FAIL %s_result: got %o expected %o", name, r, exp_res);
        end
        checks++;
        if (o !== exp_ovf) begin
            failures++;
            $display("FAIL %s_overflow: got %b expected %b", name, o, exp_ovf);
        end
    endtask

    task automatic test_add_carry;
        test_vector("half_plus_half", {1'b0, 6'o40, 24'o40000000}, {1'b0, 6'o40, 24'o40000000},
                    1'b0, {1'b0, 6'o41, 24'o01000000}, 1'b0);
    endtask

    task automatic test_cancel;
        test_vector("cancel_pos", {1'b0, 6'o40, 24'o40000000}, {1'b0, 6'o40, 24'o40000000},
                    1'b1, {1'b0, 6'o00, 24'o00000000}, 1'b0);
        test_vector("cancel_neg", {1'b1, 6'o40, 24'o40000000}, {1'b1, 6'o40, 24'o40000000},
                    1'b1, {1'b1, 6'o00, 24'o00000000}, 1'b0);
    endtask

    task automatic test_negative_result;
        test_vector("neg_result", {1'b0, 6'o40, 24'o20000000}, {1'b0, 6'o40, 24'o40000000},
                    1'b1, {1'b1, 6'o40, 24'o20000000}, 1'b0);
    endtask

    task automatic test_overflow;
        test_vector("exp_overflow", {1'b0, 6'o77, 24'o77000000}, {1'b0, 6'o77, 24'o77000000},
                    1'b0, {1'b0, 6'o00, 24'o01760000}, 1'b1);
        test_vector("exp_underflow", {1'b0, 6'o00, 24'o00000100}, {1'b0, 6'o00, 24'o00000000},
                    1'b0, {1'b0, 6'o00, 24'o00000000}, 1'b1);
    endtask

    task automatic test_rounding;
`ifdef MIX_FADD_ROUND_EN
        test_vector("round_tie", {1'b0, 6'o40, 24'o01000000}, {1'b0, 6'o34, 24'o40000000},
                    1'b0, {1'b0, 6'o40, 24'o01000001}, 1'b0);
        test_vector("sticky_sub", {1'b0, 6'o40, 24'o40000000}, {1'b0, 6'o20, 24'o77777777},
                    1'b1, {1'b0, 6'o40, 24'o40000000}, 1'b0);
`else
        test_vector("round_tie", {1'b0, 6'o40, 24'o01000000}, {1'b0, 6'o34, 24'o40000000},
                    1'b0, {1'b0, 6'o40, 24'o01000000}, 1'b0);
        test_vector("sticky_sub", {1'b0, 6'o40, 24'o40000000}, {1'b0, 6'o20, 24'o77777777},
                    1'b1, {1'b0, 6'o40, 24'o37777777}, 1'b0);
`endif
    endtask

    task automatic test_zero_operands;
        test_vector("zero_in1", {1'b1, 6'o00, 24'o00000000}, {1'b0, 6'o33, 24'o03333333},
                    1'b0, {1'b0, 6'o33, 24'o03333333}, 1'b0);
        test_vector("unnorm_2byte", {1'b0, 6'o40, 24'o00000100}, {1'b0, 6'o00, 24'o00000000},
                    1'b0, {1'b0, 6'o36, 24'o01000000}, 1'b0);
        test_vector("unnorm_1byte", {1'b0, 6'o40, 24'o00010000}, {1'b0, 6'o00, 24'o00000000},
                    1'b0, {1'b0, 6'o37, 24'o01000000}, 1'b0);
        test_vector("deep_cancel", {1'b0, 6'o41, 24'o01000000}, {1'b0, 6'o40, 24'o77777777},
                    1'b1, {1'b0, 6'o35, 24'o01000000}, 1'b0);
    endtask

    task automatic test_reset_abort;
        int dones;
        in1   = {1'b0, 6'o40, 24'o40000000};
        in2   = {1'b0, 6'o40, 24'o40000000};
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (result !== 31'd0 || done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: got res=%o done=%b busy=%b ovf=%b expected all zero",
                     result, done, busy, overflow);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
    endtask

    task automatic test_start_while_busy;
        int          dones;
        logic [30:0] seen;
        seen  = '0;
        dones = 0;
        in1   = {1'b0, 6'o40, 24'o40000000};
        in2   = {1'b0, 6'o40, 24'o40000000};
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                in1   = {1'b0, 6'o33, 24'o03333333};
                in2   = {1'b1, 6'o00, 24'o00000000};
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                seen = result;
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL busy_start_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (seen !== {1'b0, 6'o41, 24'o01000000}) begin
            failures++;
            $display("FAIL busy_start_result: got %o expected %o", seen,
                     {1'b0, 6'o41, 24'o01000000});
        end
    endtask

    task automatic test_back_to_back;
        logic [30:0] r;
        logic        o;
        int          lat;
        do_op({1'b0, 6'o40, 24'o20000000}, {1'b0, 6'o40, 24'o20000000}, 1'b0, r, o, lat);
        checks++;
        if (r !== {1'b0, 6'o40, 24'o40000000} || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got %o done=%b expected %o done=1", r, done,
                     {1'b0, 6'o40, 24'o40000000});
        end
        do_op({1'b0, 6'o77, 24'o77000000}, {1'b0, 6'o77, 24'o77000000}, 1'b0, r, o, lat);
        checks++;
        if (r !== {1'b0, 6'o00, 24'o01760000} || o !== 1'b1 || lat > 10) begin
            failures++;
            $display("FAIL b2b_second: got %o ovf=%b lat=%0d expected %o ovf=1 lat<=10", r, o, lat,
                     {1'b0, 6'o00, 24'o01760000});
        end
        @(posedge clk); #1;
        checks++;
        if (result !== {1'b0, 6'o00, 24'o01760000} || overflow !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold: got %o ovf=%b done=%b expected held result, done=0",
                     result, overflow, done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        in1      = '0;
        in2      = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_add_carry();
        test_cancel();
        test_negative_result();
        test_overflow();
        test_rounding();
        test_zero_operands();
        test_back_to_back();
        test_reset_abort();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
